// File: rtl/screen_pkg.sv
// Shared colours, panel geometry and menu FSM states for the OLED screen renderers.
package screen_pkg;

  localparam logic [15:0] GREEN   = 16'h07E0;
  localparam logic [15:0] YELLOW  = 16'hFFE0;
  localparam logic [15:0] RED     = 16'hF800;
  localparam logic [15:0] BLACK   = 16'h0000;
  localparam logic [15:0] WHITE   = 16'hFFFF;
  localparam logic [15:0] BROWN   = 16'hA145;
  localparam logic [15:0] SKYBLUE = 16'h867D;

  localparam int OLED_W = 96;
  localparam int OLED_H = 64;

  typedef enum logic [1:0] {
    S_INTRO   = 2'd0,
    S_BROWSE  = 2'd1,
    S_CONFIRM = 2'd2,
    S_DONE    = 2'd3
  } menu_state_e;

  function automatic logic in_rect(input int px, input int py, input int x0, input int y0,
                                   input int w, input int h);
    return (px >= x0) && (px < x0 + w) && (py >= y0) && (py < y0 + h);
  endfunction

endpackage

// File: rtl/frame_blink_timer.sv
// Counts frame_begin pulses and produces a blink phase that toggles every half_period frames.
module frame_blink_timer #(
  parameter int CW = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic          frame_begin,
  input  logic          blink_en,
  input  logic [CW-1:0] half_period,
  output logic [CW-1:0] frame_count,
  output logic          blink_phase
);

  logic [CW-1:0] frame_cnt_q, frame_cnt_d;
  logic [CW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (clear) begin
      frame_cnt_d = '0;
      blink_cnt_d = '0;
      phase_d     = 1'b1;
    end else begin
      if (frame_begin) frame_cnt_d = frame_cnt_q + CW'(1);
      // A disabled blinker parks with the highlight showing.
      if (!blink_en) begin
        blink_cnt_d = '0;
        phase_d     = 1'b1;
      end else if (frame_begin) begin
        if (blink_cnt_q >= half_period - CW'(1)) begin
          blink_cnt_d = '0;
          phase_d     = ~phase_q;
        end else begin
          blink_cnt_d = blink_cnt_q + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      frame_cnt_q <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  assign frame_count = frame_cnt_q;
  assign blink_phase = phase_q;

endmodule

// File: rtl/menu_screen_ctrl.sv
// Paged vertical menu on the 96x64 OLED: blinking highlight, button navigation, confirm flash.
//   state     | meaning
//   S_INTRO   | buttons ignored until INTRO_FRAMES frames have passed
//   S_BROWSE  | up/down move highlight, left/right change page, centre confirms
//   S_CONFIRM | fast blink for CONFIRM_FRAMES frames
//   S_DONE    | selection reported, highlight solid, left goes back to browsing
module menu_screen_ctrl
  import screen_pkg::*;
#(
  parameter int          NUM_ITEMS      = 3,
  parameter int          NUM_PAGES      = 2,
  parameter int          ITEM_X0        = 43,
  parameter int          ITEM_W         = 11,
  parameter int          ITEM_Y0        = 18,
  parameter int          ITEM_H         = 9,
  parameter int          ITEM_PITCH     = 11,
  parameter int          BLINK_FRAMES   = 15,
  parameter int          INTRO_FRAMES   = 30,
  parameter int          CONFIRM_FRAMES = 20,
  parameter logic [15:0] FG             = YELLOW,
  parameter logic [15:0] HILITE         = GREEN,
  parameter logic [15:0] BG             = BLACK,
  localparam int         IW             = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1,
  localparam int         PW             = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enable,
  input  logic          frame_begin,
  input  logic          btn_up,
  input  logic          btn_down,
  input  logic          btn_left,
  input  logic          btn_right,
  input  logic          btn_centre,
  input  logic [6:0]    x,
  input  logic [5:0]    y,
  output logic [15:0]   oled_data,
  output logic [IW-1:0] sel_index,
  output logic [PW-1:0] page,
  output logic          select_valid,
  output logic          busy
);

  localparam int            CW           = 8;
  localparam logic [CW-1:0] INTRO_LAST   = CW'(INTRO_FRAMES - 1);
  localparam logic [CW-1:0] CONFIRM_LAST = CW'(CONFIRM_FRAMES - 1);
  localparam logic [IW-1:0] SEL_LAST     = IW'(NUM_ITEMS - 1);
  localparam logic [PW-1:0] PAGE_LAST    = PW'(NUM_PAGES - 1);

  menu_state_e   state_q, state_d;
  logic [IW-1:0] sel_q, sel_d;
  logic [PW-1:0] page_q, page_d;
  logic          busy_q, busy_d;
  logic          select_valid_q, select_valid_d;
  logic [15:0]   oled_q, oled_d;

  logic          tmr_clear;
  logic          blink_en;
  logic [CW-1:0] half_period;
  logic [CW-1:0] frame_count;
  logic          blink_phase;

  frame_blink_timer #(.CW(CW)) u_timer (
    .clock       (clock),
    .reset       (reset),
    .clear       (tmr_clear),
    .frame_begin (frame_begin),
    .blink_en    (blink_en),
    .half_period (half_period),
    .frame_count (frame_count),
    .blink_phase (blink_phase)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    page_d  = page_q;
    if (!enable) begin
      state_d = S_INTRO;
    end else begin
      unique case (state_q)
        S_INTRO: begin
          if (frame_begin && (frame_count == INTRO_LAST)) state_d = S_BROWSE;
        end
        S_BROWSE: begin
          // Only the highest-priority pulse acts; the rest are dropped.
          if (btn_centre) begin
            state_d = S_CONFIRM;
          end else if (btn_up) begin
            sel_d = (sel_q == '0) ? SEL_LAST : sel_q - IW'(1);
          end else if (btn_down) begin
            sel_d = (sel_q == SEL_LAST) ? '0 : sel_q + IW'(1);
          end else if (btn_right) begin
            if (page_q < PAGE_LAST) begin
              page_d = page_q + PW'(1);
              sel_d  = '0;
            end
          end else if (btn_left) begin
            if (page_q != '0) begin
              page_d = page_q - PW'(1);
              sel_d  = '0;
            end
          end
        end
        S_CONFIRM: begin
          if (frame_begin && (frame_count == CONFIRM_LAST)) state_d = S_DONE;
        end
        S_DONE: begin
          if (btn_left) state_d = S_BROWSE;
        end
        default: state_d = S_INTRO;
      endcase
    end

    busy_d         = (state_d == S_INTRO) || (state_d == S_CONFIRM);
    select_valid_d = (state_d == S_DONE) && (state_q != S_DONE);
    tmr_clear      = (state_d != state_q) || !enable;
    blink_en       = (state_q != S_DONE);
    half_period    = (state_q == S_CONFIRM) ? CW'(2) : CW'(BLINK_FRAMES);
  end

  // Pixel colour from the registered menu state, so output lags x/y by exactly one cycle.
  always_comb begin
    oled_d = BG;
    if ((int'(x) < OLED_W) && (int'(y) < OLED_H)) begin
      for (int i = 0; i < NUM_ITEMS; i++) begin
        if (in_rect(int'(x), int'(y), ITEM_X0, ITEM_Y0 + i * ITEM_PITCH, ITEM_W, ITEM_H)) begin
          if (!in_rect(int'(x), int'(y), ITEM_X0 + 1, ITEM_Y0 + i * ITEM_PITCH + 1,
                       ITEM_W - 2, ITEM_H - 2)) begin
            oled_d = FG;
          end else if ((i == int'(sel_q)) && blink_phase) begin
            oled_d = HILITE;
          end
        end
      end
      if ((page_q < PAGE_LAST) && in_rect(int'(x), int'(y), 86, 57, 3, 3)) oled_d = FG;
      if ((page_q != '0) && in_rect(int'(x), int'(y), 7, 57, 3, 3)) oled_d = FG;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= S_INTRO;
      sel_q          <= '0;
      page_q         <= '0;
      busy_q         <= 1'b1;
      select_valid_q <= 1'b0;
      oled_q         <= BG;
    end else begin
      state_q        <= state_d;
      sel_q          <= sel_d;
      page_q         <= page_d;
      busy_q         <= busy_d;
      select_valid_q <= select_valid_d;
      oled_q         <= oled_d;
    end
  end

  assign oled_data    = oled_q;
  assign sel_index    = sel_q;
  assign page         = page_q;
  assign select_valid = select_valid_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_menu_screen_ctrl.sv
// Scoreboard bench for menu_screen_ctrl: directed walk through the menu, then random buttons and frames.
module tb_menu_screen_ctrl;

  localparam int N_ITEMS   = 3;
  localparam int N_PAGES   = 2;
  localparam int X0        = 43;
  localparam int W         = 11;
  localparam int Y0        = 18;
  localparam int H         = 9;
  localparam int PITCH     = 11;
  localparam int BLINK     = 15;
  localparam int INTRO     = 30;
  localparam int CONFIRM   = 20;
  localparam logic [15:0] C_FG = 16'hFFE0;
  localparam logic [15:0] C_HI = 16'h07E0;
  localparam logic [15:0] C_BG = 16'h0000;

  localparam int M_INTRO = 0, M_BROWSE = 1, M_CONFIRM = 2, M_DONE = 3;

  // button vector order: {centre, up, down, right, left}
  localparam logic [4:0] B_N = 5'b00000;
  localparam logic [4:0] B_C = 5'b10000;
  localparam logic [4:0] B_U = 5'b01000;
  localparam logic [4:0] B_D = 5'b00100;
  localparam logic [4:0] B_R = 5'b00010;
  localparam logic [4:0] B_L = 5'b00001;

  logic        clock = 1'b0;
  logic        reset, enable, frame_begin;
  logic        btn_up, btn_down, btn_left, btn_right, btn_centre;
  logic [6:0]  x;
  logic [5:0]  y;
  logic [15:0] oled_data;
  logic [1:0]  sel_index;
  logic [0:0]  page;
  logic        select_valid, busy;

  menu_screen_ctrl dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .frame_begin  (frame_begin),
    .btn_up       (btn_up),
    .btn_down     (btn_down),
    .btn_left     (btn_left),
    .btn_right    (btn_right),
    .btn_centre   (btn_centre),
    .x            (x),
    .y            (y),
    .oled_data    (oled_data),
    .sel_index    (sel_index),
    .page         (page),
    .select_valid (select_valid),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] pix;
    int          sel;
    int          pg;
    bit          busy;
    bit          sv;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc_n = 0;

  // reference model state
  int m_mode = M_INTRO, m_sel = 0, m_pg = 0, m_fc = 0, m_bc = 0;
  bit m_ph = 1'b1;

  int probe_x[5] = '{43, 48, 48, 7, 87};
  int probe_y[5] = '{29, 33, 22, 57, 58};
  int probe_i = 0;

  function automatic logic [15:0] ref_pixel(input int px, input int py);
    int rel, item, row;
    if (px >= 96 || py >= 64) return C_BG;
    if (py >= 57 && py <= 59) begin
      if (px >= 7 && px <= 9 && m_pg > 0) return C_FG;
      if (px >= 86 && px <= 88 && m_pg < N_PAGES - 1) return C_FG;
    end
    if (px >= X0 && px < X0 + W && py >= Y0) begin
      rel  = py - Y0;
      item = rel / PITCH;
      row  = rel % PITCH;
      if (item < N_ITEMS && row < H) begin
        if (px == X0 || px == X0 + W - 1 || row == 0 || row == H - 1) return C_FG;
        if (item == m_sel && m_ph) return C_HI;
      end
    end
    return C_BG;
  endfunction

  task automatic model_step(input bit rst, input bit en, input bit fb, input logic [4:0] btn,
                            input int px, input int py);
    exp_t e;
    int   nm, ns, np;
    bit   c, u, d, r, l;
    {c, u, d, r, l} = btn;
    e.sv = 1'b0;
    if (rst) begin
      m_mode = M_INTRO; m_sel = 0; m_pg = 0; m_fc = 0; m_bc = 0; m_ph = 1'b1;
      e.pix = C_BG;
    end else begin
      e.pix = ref_pixel(px, py);
      nm = m_mode; ns = m_sel; np = m_pg;
      if (!en) nm = M_INTRO;
      else begin
        case (m_mode)
          M_INTRO:   if (fb && m_fc + 1 == INTRO) nm = M_BROWSE;
          M_BROWSE: begin
            if (c) nm = M_CONFIRM;
            else if (u) ns = (m_sel + N_ITEMS - 1) % N_ITEMS;
            else if (d) ns = (m_sel + 1) % N_ITEMS;
            else if (r) begin
              if (m_pg < N_PAGES - 1) begin np = m_pg + 1; ns = 0; end
            end else if (l) begin
              if (m_pg > 0) begin np = m_pg - 1; ns = 0; end
            end
          end
          M_CONFIRM: if (fb && m_fc + 1 == CONFIRM) nm = M_DONE;
          default:   if (l) nm = M_BROWSE;
        endcase
      end
      e.sv = (nm == M_DONE) && (m_mode != M_DONE);
      if (nm != m_mode || !en) begin
        m_fc = 0; m_bc = 0; m_ph = 1'b1;
      end else begin
        if (fb) m_fc++;
        if (m_mode == M_DONE) begin
          m_bc = 0; m_ph = 1'b1;
        end else if (fb) begin
          m_bc++;
          if (m_bc == ((m_mode == M_CONFIRM) ? 2 : BLINK)) begin
            m_bc = 0; m_ph = ~m_ph;
          end
        end
      end
      m_mode = nm; m_sel = ns; m_pg = np;
    end
    e.sel  = m_sel;
    e.pg   = m_pg;
    e.busy = (m_mode == M_INTRO) || (m_mode == M_CONFIRM);
    q.push_back(e);
  endtask

  task automatic step(input bit rst, input bit en, input bit fb, input logic [4:0] btn,
                      input int px, input int py);
    reset       = rst;
    enable      = en;
    frame_begin = fb;
    {btn_centre, btn_up, btn_down, btn_right, btn_left} = btn;
    x = 7'(px);
    y = 6'(py);
    model_step(rst, en, fb, btn, px, py);
    @(negedge clock);
  endtask

  // directed cycles cycle the probe points around the boxes and arrows
  task automatic run(input bit rst, input bit en, input bit fb, input logic [4:0] btn);
    step(rst, en, fb, btn, probe_x[probe_i], probe_y[probe_i]);
    probe_i = (probe_i + 1) % 5;
  endtask

  task automatic frames(input int n);
    for (int f = 0; f < n; f++) begin
      for (int k = 0; k < 3; k++) run(1'b0, 1'b1, 1'b0, B_N);
      run(1'b0, 1'b1, 1'b1, B_N);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc_n, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      cyc_n++;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("oled_data", 32'(oled_data), 32'(e.pix));
        chk("sel_index", 32'(sel_index), 32'(e.sel));
        chk("page", 32'(page), 32'(e.pg));
        chk("busy", 32'(busy), 32'(e.busy));
        chk("select_valid", 32'(select_valid), 32'(e.sv));
      end
    end
  end

  initial begin : driver
    logic [4:0] b;
    int         px, py;
    for (int i = 0; i < 3; i++) run(1'b1, 1'b0, 1'b0, B_N);
    // intro: presses must be ignored
    for (int f = 0; f < INTRO; f++) begin
      run(1'b0, 1'b1, 1'b0, B_N);
      run(1'b0, 1'b1, 1'b0, 5'($urandom_range(0, 31)));
      run(1'b0, 1'b1, 1'b0, B_N);
      run(1'b0, 1'b1, 1'b1, B_N);
    end
    frames(1);
    run(1'b0, 1'b1, 1'b0, B_U);
    for (int i = 0; i < 3; i++) begin
      run(1'b0, 1'b1, 1'b0, B_D);
      run(1'b0, 1'b1, 1'b0, B_N);
    end
    run(1'b0, 1'b1, 1'b0, B_U);
    frames(35);
    run(1'b0, 1'b1, 1'b0, B_R);
    frames(1);
    run(1'b0, 1'b1, 1'b0, B_R);
    frames(1);
    run(1'b0, 1'b1, 1'b0, B_C | B_U);
    frames(CONFIRM + 2);
    run(1'b0, 1'b1, 1'b0, B_U | B_R | B_D);
    run(1'b0, 1'b1, 1'b0, B_L);
    run(1'b0, 1'b1, 1'b0, B_D | B_L);
    run(1'b0, 1'b1, 1'b0, B_L);
    frames(32);
    run(1'b0, 1'b1, 1'b0, B_C);
    frames(5);
    run(1'b0, 1'b0, 1'b0, B_N);
    frames(INTRO + 1);
    run(1'b0, 1'b1, 1'b0, B_C);
    frames(CONFIRM - 1);
    run(1'b0, 1'b1, 1'b0, B_N);
    run(1'b1, 1'b1, 1'b1, B_N);
    run(1'b1, 1'b1, 1'b0, B_N);
    frames(INTRO + 2);

    for (int i = 0; i < 9000; i++) begin
      b = 5'b0;
      b[4] = ($urandom_range(0, 39) == 0);
      for (int k = 0; k < 4; k++) b[k] = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 1) == 0) begin
        px = $urandom_range(0, 127);
        py = $urandom_range(0, 63);
      end else begin
        px = $urandom_range(0, 2) == 0 ? $urandom_range(5, 10) :
             ($urandom_range(0, 1) == 0 ? $urandom_range(84, 90) : $urandom_range(41, 55));
        py = $urandom_range(15, 60);
      end
      step($urandom_range(0, 2999) == 0, $urandom_range(0, 399) != 0,
           $urandom_range(0, 3) == 0, b, px, py);
    end
    run(1'b0, 1'b1, 1'b0, B_N);

    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clock);
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain left=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/menu_screen_ctrl.md
Name: menu_screen_ctrl

Overview:
- Parametrised, stateful successor to the fixed game/control screen renderers.
- Draws a vertical list of NUM_ITEMS selectable boxes across NUM_PAGES pages on the 96x64 OLED.
- Moves a blinking highlight on debounced button pulses and flashes the confirmed item.
- Reports the chosen page/item to the game top level. Sits between the button debouncers and the OLED pixel mux.

Parameters:
- NUM_ITEMS, 3, selectable boxes per page (2..8)
- NUM_PAGES, 2, number of pages (1..8)
- ITEM_X0, 43, left column of every box
- ITEM_W, 11, box width in pixels
- ITEM_Y0, 18, top row of item 0
- ITEM_H, 9, box height in pixels
- ITEM_PITCH, 11, row offset between consecutive items
- BLINK_FRAMES, 15, frames per highlight blink half-period
- INTRO_FRAMES, 30, frames buttons are ignored after enable
- CONFIRM_FRAMES, 20, frames of confirm flash
- FG, 16'hFFE0, border/text colour
- HILITE, 16'h07E0, selected-item fill
- BG, 16'h0000, background

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  screen active; low forces return to S_INTRO
- frame_begin  in  1  one-cycle pulse at start of each OLED frame
- btn_up, btn_down, btn_left, btn_right, btn_centre  in  1 each  debounced single-cycle pulses
- x  in  7  pixel column (0..95)
- y  in  6  pixel row (0..63)
- oled_data  out  16  registered pixel colour
- sel_index  out  IW=max(1,clog2(NUM_ITEMS))  current item
- page  out  PW=max(1,clog2(NUM_PAGES))  current page
- select_valid  out  1  one-cycle pulse when a selection completes
- busy  out  1  high in S_INTRO and S_CONFIRM

Behaviour:
- Reset values: oled_data=BG, sel_index=0, page=0, select_valid=0, busy=1. FSM=S_INTRO; frame/blink counters 0; blink_phase=1.
- Pixel path has 1-cycle latency: oled_data(t+1) = colour for x,y(t). It is independent of FSM update order and uses state registered at t.
- Item i region: x in [ITEM_X0, ITEM_X0+ITEM_W-1], y in [ITEM_Y0+i*ITEM_PITCH, +ITEM_H-1]. Edge pixels = FG.
- Interior of item == sel_index = HILITE when blink_phase=1, else BG. All other pixels = BG.
- Page arrows: right arrow at x=86..88, y=57..59 when page<NUM_PAGES-1. Left arrow at x=7..9, same rows, when page>0. Both in FG.
- frame_counter advances only on frame_begin. It clears on every state transition.
- FSM states:
  - S_INTRO: buttons ignored. Leaves to S_BROWSE after INTRO_FRAMES frame_begin pulses.
  - S_BROWSE: btn_up gives sel=(sel==0)?NUM_ITEMS-1:sel-1 (wraps). btn_down increments with wrap to 0. btn_right: page+1, saturates at NUM_PAGES-1, sel:=0 only if page changed. btn_left: page-1, saturates at 0, sel:=0 only if page changed. btn_centre goes to S_CONFIRM.
  - S_CONFIRM: blink half-period forced to 2 frames. After CONFIRM_FRAMES frames goes to S_DONE.
  - S_DONE: select_valid=1 exactly on the entry cycle. sel/page held; highlight solid (blink_phase=1). btn_left returns to S_BROWSE; other buttons ignored.
- Simultaneous buttons: one action per cycle, priority centre > up > down > right > left. Lower-priority pulses are dropped.
- Blink: blink_phase toggles when the blink counter reaches its half-period. It resets to 1 on entering S_BROWSE.
- enable low in any state: next cycle FSM=S_INTRO, counters 0; sel/page retained; select_valid never asserted.
- reset mid-confirm: all state returns to reset values; no select_valid pulse.
- Coordinates outside 0..95 / 0..63 render BG.

Decomposition:
- Shared package screen_pkg: colour localparams (GREEN, YELLOW, RED, BLACK, WHITE, BROWN, SKYBLUE), OLED_W=96, OLED_H=64, FSM state enum.
- One sub-module frame_blink_timer: frame_begin counter with programmable half-period, clear input, blink_phase output. It is used for the intro, blink and confirm timing.

Test Plan:
- Reset, then enable=1 and 30 frame_begin pulses: busy 1→0 after the 30th pulse. Buttons pressed before that leave sel_index=0.
- In S_BROWSE, btn_up from sel=0 gives sel_index=2. Then btn_down three times gives 2→0→1→2.
- btn_right twice with NUM_PAGES=2: page=1 and sel_index reset to 0 once. Right arrow disappears; left arrow appears at (7,57).
- Same-cycle btn_centre+btn_up: enters S_CONFIRM, sel unchanged. After 20 frames select_valid pulses exactly one cycle; page/sel match.
- Pixel check at sel=1: x=43,y=29 reads FG one cycle later. x=48,y=33 alternates HILITE/BG every 15 frames; x=48,y=22 stays BG.
- enable dropped during S_CONFIRM: next cycle busy=1 (S_INTRO), no select_valid, sel/page preserved.
